// File: rtl/pal_sync_gen_pkg.sv
// pal_sync_gen_pkg
//   Shared PAL raster timing defaults and the line-type encoding, so the VPU
//   and the sync generator agree on one set of numbers.
//   Timing is expressed in 8 MHz pixel clocks (512 per 64 us line).
package pal_sync_gen_pkg;

  localparam int unsigned H_TOTAL_DEF      = 512; // clocks per line (64 us)
  localparam int unsigned HSYNC_W_DEF      = 38;  // 4.7 us line sync
  localparam int unsigned EQ_W_DEF         = 19;  // 2.35 us equalising pulse
  localparam int unsigned BROAD_W_DEF      = 218; // 27.3 us broad pulse
  localparam int unsigned V_TOTAL_DEF      = 312; // lines per frame
  localparam int unsigned V_BLANK_DEF      = 25;  // lines 0..V_BLANK-1 blanked
  localparam int unsigned BLINK_FRAMES_DEF = 16;  // frames per blink half-period

  // Kind of sync pattern carried by a line.
  typedef enum logic [1:0] {
    LT_EQ     = 2'd0,
    LT_BROAD  = 2'd1,
    LT_NORMAL = 2'd2
  } line_type_e;

endpackage

// File: rtl/pal_sync_gen.sv
// pal_sync_gen
//   Non-interlaced PAL raster timing generator for the VPU pixel pipeline.
//   Ports:
//     pixel_clk   in   pixel clock, sole clock
//     rst         in   synchronous reset, active-high
//     cntHS[8:0]  out  horizontal position 0..H_TOTAL-1
//     cntVS[8:0]  out  line number 0..V_TOTAL-1
//     vbl         out  vertical blanking, lines 0..V_BLANK-1
//     hsync       out  high while cntHS < HSYNC_W
//     out_sync    out  composite sync level (0 = sync tip)
//     frame_start out  one-clock pulse at (cntHS, cntVS) = (0, 0)
//     blink       out  toggles every BLINK_FRAMES frames
//   All outputs are registered; decodes are taken from the next counter
//   state so they line up with the counters presented in the same cycle.
module pal_sync_gen
  import pal_sync_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned HSYNC_W      = HSYNC_W_DEF,
  parameter int unsigned EQ_W         = EQ_W_DEF,
  parameter int unsigned BROAD_W      = BROAD_W_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned V_BLANK      = V_BLANK_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic       pixel_clk,
  input  logic       rst,
  output logic [8:0] cntHS,
  output logic [8:0] cntVS,
  output logic       vbl,
  output logic       hsync,
  output logic       out_sync,
  output logic       frame_start,
  output logic       blink
);

  localparam logic [8:0] H_MAX     = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_MAX     = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_BLANK_C = 9'(V_BLANK);
  localparam logic [8:0] HSYNC_C   = 9'(HSYNC_W);
  localparam logic [3:0] FRAME_MAX = 4'(BLINK_FRAMES - 1);

  // Window bounds are 10 bits so the second-half pulse end cannot overflow.
  localparam logic [9:0] HALF_C    = 10'(H_TOTAL / 2);
  localparam logic [9:0] EQ_END1   = 10'(EQ_W);
  localparam logic [9:0] EQ_END2   = 10'(H_TOTAL / 2 + EQ_W);
  localparam logic [9:0] BR_END1   = 10'(BROAD_W);
  localparam logic [9:0] BR_END2   = 10'(H_TOTAL / 2 + BROAD_W);
  localparam logic [9:0] HSYNC_END = 10'(HSYNC_W);

  logic [8:0] cnt_hs_q, cnt_hs_d;
  logic [8:0] cnt_vs_q, cnt_vs_d;
  logic       vbl_q, vbl_d;
  logic       hsync_q, hsync_d;
  logic       out_sync_q, out_sync_d;
  logic       frame_start_q, frame_start_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       blink_q, blink_d;
  logic       wrap_h;

  // Lines 0,1 and 5,6 equalising; 2..4 broad; everything else normal.
  function automatic line_type_e line_type(input logic [8:0] v);
    if (v < 9'd2) return LT_EQ;
    if (v < 9'd5) return LT_BROAD;
    if (v < 9'd7) return LT_EQ;
    return LT_NORMAL;
  endfunction

  // True while the composite sync is at the tip for position (h, v).
  function automatic logic sync_tip(input logic [8:0] h, input logic [8:0] v);
    logic [9:0] hx;
    hx = {1'b0, h};
    case (line_type(v))
      LT_EQ:    return (hx < EQ_END1) || (hx >= HALF_C && hx < EQ_END2);
      LT_BROAD: return (hx < BR_END1) || (hx >= HALF_C && hx < BR_END2);
      default:  return hx < HSYNC_END;
    endcase
  endfunction

  always_comb begin
    wrap_h   = (cnt_hs_q == H_MAX);
    cnt_hs_d = wrap_h ? '0 : cnt_hs_q + 9'd1;
    cnt_vs_d = cnt_vs_q;
    if (wrap_h) begin
      cnt_vs_d = (cnt_vs_q == V_MAX) ? '0 : cnt_vs_q + 9'd1;
    end

    vbl_d         = (cnt_vs_d < V_BLANK_C);
    hsync_d       = (cnt_hs_d < HSYNC_C);
    out_sync_d    = ~sync_tip(cnt_hs_d, cnt_vs_d);
    frame_start_d = (cnt_hs_d == '0) && (cnt_vs_d == '0);

    // Frame counter advances together with the registered frame_start pulse,
    // so blink changes in the very cycle frame_start is seen high.
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start_d) begin
      if (frame_cnt_q == FRAME_MAX) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 4'd1;
      end
    end
  end

  // Reset leaves the counters at (0,0) with the matching decodes, but
  // without a frame_start pulse: the partial frame is not announced.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      cnt_hs_q      <= '0;
      cnt_vs_q      <= '0;
      vbl_q         <= 1'b1;
      hsync_q       <= 1'b1;
      out_sync_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      blink_q       <= 1'b0;
    end else begin
      cnt_hs_q      <= cnt_hs_d;
      cnt_vs_q      <= cnt_vs_d;
      vbl_q         <= vbl_d;
      hsync_q       <= hsync_d;
      out_sync_q    <= out_sync_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_q       <= blink_d;
    end
  end

  assign cntHS       = cnt_hs_q;
  assign cntVS       = cnt_vs_q;
  assign vbl         = vbl_q;
  assign hsync       = hsync_q;
  assign out_sync    = out_sync_q;
  assign frame_start = frame_start_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_pal_sync_gen.sv
// tb_pal_sync_gen
//   Bench for pal_sync_gen: one instance at full PAL timing and one at a
//   shrunken raster so whole-frame and blink behaviour fit in a short run.
module tb_pal_sync_gen;

  localparam int unsigned SH  = 64;
  localparam int unsigned SHS = 5;
  localparam int unsigned SEQ = 2;
  localparam int unsigned SBR = 27;
  localparam int unsigned SV  = 20;
  localparam int unsigned SVB = 8;
  localparam int unsigned SBF = 4;
  localparam longint      SFRAME = SH * SV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f = 1'b1;
  logic [8:0] hs_f, vs_f;
  logic       vbl_f, hsync_f, os_f, fs_f, bl_f;

  logic       rst_s = 1'b1;
  logic [8:0] hs_s, vs_s;
  logic       vbl_s, hsync_s, os_s, fs_s, bl_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Clocks since the last edge at which each reset was sampled high.
  longint t_f = 0;
  longint t_s = 0;
  always @(posedge clk) begin
    t_f <= rst_f ? 64'sd0 : t_f + 1;
    t_s <= rst_s ? 64'sd0 : t_s + 1;
  end

  pal_sync_gen u_full (
    .pixel_clk(clk), .rst(rst_f), .cntHS(hs_f), .cntVS(vs_f), .vbl(vbl_f),
    .hsync(hsync_f), .out_sync(os_f), .frame_start(fs_f), .blink(bl_f)
  );

  pal_sync_gen #(
    .H_TOTAL(SH), .HSYNC_W(SHS), .EQ_W(SEQ), .BROAD_W(SBR),
    .V_TOTAL(SV), .V_BLANK(SVB), .BLINK_FRAMES(SBF)
  ) u_small (
    .pixel_clk(clk), .rst(rst_s), .cntHS(hs_s), .cntVS(vs_s), .vbl(vbl_s),
    .hsync(hsync_s), .out_sync(os_s), .frame_start(fs_s), .blink(bl_s)
  );

  // Reference: everything follows from elapsed clocks since reset.
  // Result packing: {h[8:0], v[8:0], vbl, hsync, out_sync, frame_start, blink}
  function automatic logic [22:0] model(input longint t, input longint H, input longint V,
                                        input longint HS, input longint EQ, input longint BR,
                                        input longint VB, input longint BF);
    longint p, h, v, nfr, half;
    logic eq, br, tip, fs, bl, vb, hsy;
    p    = t % (H * V);
    h    = p % H;
    v    = p / H;
    nfr  = t / (H * V);
    half = H / 2;
    eq   = (h < EQ) || (h >= half && h < half + EQ);
    br   = (h < BR) || (h >= half && h < half + BR);
    if (v <= 1 || v == 5 || v == 6) tip = eq;
    else if (v <= 4)                tip = br;
    else                            tip = (h < HS);
    fs  = (p == 0) && (t != 0);
    bl  = ((nfr / BF) % 2) == 1;
    vb  = (v < VB);
    hsy = (h < HS);
    return {h[8:0], v[8:0], vb, hsy, ~tip, fs, bl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_f(input longint target);
    int guard = 0;
    while (t_f < target && guard < 200000) begin
      tick();
      guard++;
    end
    n_tests++;
    if (t_f != target) begin
      n_fail++;
      $display("FAIL advance_f: reached t=%0d, required t=%0d", t_f, target);
    end
  endtask

  task automatic test_reset();
    rst_f = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({hs_f, vs_f, vbl_f, hsync_f, os_f, fs_f, bl_f} !== {9'd0, 9'd0, 5'b11000}) begin
        n_fail++;
        $display("FAIL reset_state: got hs=%0d vs=%0d vbl=%b hsync=%b sync=%b fs=%b blink=%b, want 0 0 1 1 0 0 0",
                 hs_f, vs_f, vbl_f, hsync_f, os_f, fs_f, bl_f);
      end
    end
    rst_f = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      n_tests++;
      if ({hs_f, vs_f, vbl_f, os_f, fs_f} !== {9'(i), 9'd0, 1'b1, (i >= 19), 1'b0}) begin
        n_fail++;
        $display("FAIL release_seq: clk %0d got hs=%0d vs=%0d vbl=%b sync=%b fs=%b, want hs=%0d vs=0 vbl=1 sync=%b fs=0",
                 i, hs_f, vs_f, vbl_f, os_f, fs_f, i, (i >= 19));
      end
    end
  endtask

  task automatic test_broad_line();
    logic exp_os;
    advance_f(3 * 512);
    for (int i = 0; i < 512; i++) begin
      exp_os = !((i < 218) || (i >= 256 && i < 474));
      n_tests++;
      if ({hs_f, vs_f, vbl_f, hsync_f, os_f} !== {9'(i), 9'd3, 1'b1, (i < 38), exp_os}) begin
        n_fail++;
        $display("FAIL broad_line: got hs=%0d vs=%0d vbl=%b hsync=%b sync=%b, want hs=%0d vs=3 vbl=1 hsync=%b sync=%b",
                 hs_f, vs_f, vbl_f, hsync_f, os_f, i, (i < 38), exp_os);
      end
      tick();
    end
  endtask

  task automatic test_normal_line();
    advance_f(10 * 512);
    for (int i = 0; i < 512; i++) begin
      n_tests++;
      if ({hs_f, vs_f, vbl_f, hsync_f, os_f, fs_f} !== {9'(i), 9'd10, 1'b1, (i < 38), (i >= 38), 1'b0}) begin
        n_fail++;
        $display("FAIL normal_line: got hs=%0d vs=%0d vbl=%b hsync=%b sync=%b fs=%b, want hs=%0d vs=10 vbl=1 hsync=%b sync=%b fs=0",
                 hs_f, vs_f, vbl_f, hsync_f, os_f, fs_f, i, (i < 38), (i >= 38));
      end
      tick();
    end
  endtask

  task automatic test_vbl_edge();
    advance_f(25 * 512 - 1);
    n_tests++;
    if ({hs_f, vs_f, vbl_f} !== {9'd511, 9'd24, 1'b1}) begin
      n_fail++;
      $display("FAIL vbl_before: got hs=%0d vs=%0d vbl=%b, want 511 24 1", hs_f, vs_f, vbl_f);
    end
    tick();
    n_tests++;
    if ({hs_f, vs_f, vbl_f, os_f} !== {9'd0, 9'd25, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL vbl_after: got hs=%0d vs=%0d vbl=%b sync=%b, want 0 25 0 0", hs_f, vs_f, vbl_f, os_f);
    end
  endtask

  task automatic test_mid_reset_full();
    advance_f(26 * 512 + longint'($urandom_range(1, 511)));
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    n_tests++;
    if ({hs_f, vs_f, vbl_f, hsync_f, os_f, fs_f, bl_f} !== {9'd0, 9'd0, 5'b11000}) begin
      n_fail++;
      $display("FAIL full_mid_reset: got hs=%0d vs=%0d vbl=%b hsync=%b sync=%b fs=%b blink=%b, want 0 0 1 1 0 0 0",
               hs_f, vs_f, vbl_f, hsync_f, os_f, fs_f, bl_f);
    end
    tick();
    n_tests++;
    if ({hs_f, vs_f, fs_f} !== {9'd1, 9'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_after_reset: got hs=%0d vs=%0d fs=%b, want 1 0 0", hs_f, vs_f, fs_f);
    end
    rst_f = 1'b1;
  endtask

  task automatic test_frame_sequence();
    logic [22:0] exp;
    longint last_fs = 0;
    int n_fs = 0;
    longint run_len;
    rst_s = 1'b0;
    run_len = 13 * SFRAME + longint'($urandom_range(0, SFRAME - 1));
    for (longint c = 0; c < run_len; c++) begin
      tick();
      exp = model(t_s, SH, SV, SHS, SEQ, SBR, SVB, SBF);
      n_tests++;
      if ({hs_s, vs_s, vbl_s, hsync_s, os_s, fs_s, bl_s} !== exp) begin
        n_fail++;
        $display("FAIL frame_seq: t=%0d got {hs,vs,vbl,hsync,sync,fs,blink}=%h, want %h",
                 t_s, {hs_s, vs_s, vbl_s, hsync_s, os_s, fs_s, bl_s}, exp);
      end
      if (fs_s === 1'b1) begin
        n_fs++;
        if (n_fs > 1) begin
          n_tests++;
          if (t_s - last_fs != SFRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d clocks, want %0d", t_s - last_fs, SFRAME);
          end
        end
        last_fs = t_s;
      end
    end
    n_tests++;
    if (n_fs != 13) begin
      n_fail++;
      $display("FAIL frame_count: got %0d frame_start pulses, want 13", n_fs);
    end
  endtask

  task automatic test_mid_reset_small();
    logic [22:0] exp;
    longint pos, guard, frames;
    for (int k = 0; k < 3; k++) begin
      pos = longint'($urandom_range(SVB, SV - 1)) * SH + longint'($urandom_range(1, SH - 1));
      guard = 0;
      while ((t_s % SFRAME) != pos && guard < 4 * SFRAME) begin
        tick();
        guard++;
      end
      n_tests++;
      if ((t_s % SFRAME) != pos) begin
        n_fail++;
        $display("FAIL reset_position: got pos=%0d, want %0d", t_s % SFRAME, pos);
      end
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      n_tests++;
      if ({hs_s, vs_s, vbl_s, fs_s, bl_s} !== {9'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL small_mid_reset: got hs=%0d vs=%0d vbl=%b fs=%b blink=%b, want 0 0 1 0 0",
                 hs_s, vs_s, vbl_s, fs_s, bl_s);
      end
      frames = longint'($urandom_range(4, 5));
      for (longint c = 0; c < frames * SFRAME + 3; c++) begin
        tick();
        exp = model(t_s, SH, SV, SHS, SEQ, SBR, SVB, SBF);
        n_tests++;
        if ({hs_s, vs_s, vbl_s, hsync_s, os_s, fs_s, bl_s} !== exp) begin
          n_fail++;
          $display("FAIL after_reset: t=%0d got {hs,vs,vbl,hsync,sync,fs,blink}=%h, want %h",
                   t_s, {hs_s, vs_s, vbl_s, hsync_s, os_s, fs_s, bl_s}, exp);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_broad_line();
    test_normal_line();
    test_vbl_edge();
    test_mid_reset_full();
    test_frame_sequence();
    test_mid_reset_small();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
